// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS data-memory responder: access-type encoding,
// default depth and the responder state type.
package mips_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } mem_op_t;

  typedef enum logic {
    DM_IDLE = 1'b0,
    DM_RESP = 1'b1
  } dm_state_t;

  localparam int DM_DEPTH_WORDS = 3072;

  function automatic logic is_store_op(input mem_op_t op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane logic: byte enables and lane-replicated store data for
// stores, alignment check for all ops, and sign/zero extension for loads.
module dm_lane_align
  import mips_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        is_store,
  output logic        misalign,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] ldata
);

  mem_op_t            op_e;
  logic [15:0]        half_u;
  logic [7:0]         byte_u;
  logic signed [15:0] half_s;
  logic signed [7:0]  byte_s;
  logic signed [31:0] half_x;
  logic signed [31:0] byte_x;

  assign op_e     = mem_op_t'(op);
  assign is_store = is_store_op(op_e);

  always_comb begin
    half_u = addr_lo[1] ? rword[31:16] : rword[15:0];
    byte_u = rword[{addr_lo, 3'b000} +: 8];
    half_s = signed'(half_u);
    byte_s = signed'(byte_u);
    // Signed-to-signed assignment widens with the sign bit.
    half_x = half_s;
    byte_x = byte_s;
  end

  always_comb begin
    misalign = 1'b0;
    be       = 4'b0000;
    wlane    = 32'h0;
    ldata    = 32'h0;
    case (op_e)
      LW: begin
        misalign = |addr_lo;
        ldata    = rword;
      end
      LH: begin
        misalign = addr_lo[0];
        ldata    = unsigned'(half_x);
      end
      LHU: begin
        misalign = addr_lo[0];
        ldata    = {16'h0, half_u};
      end
      LB:  ldata = unsigned'(byte_x);
      LBU: ldata = {24'h0, byte_u};
      SW: begin
        misalign = |addr_lo;
        be       = 4'b1111;
        wlane    = wdata;
      end
      SH: begin
        misalign = addr_lo[0];
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{wdata[15:0]}};
      end
      SB: begin
        be    = 4'b0001 << addr_lo;
        wlane = {4{wdata[7:0]}};
      end
      default: ;
    endcase
    if (misalign) be = 4'b0000;
  end

endmodule

// File: rtl/mips_dm_responder.sv
// Single-cycle data-memory responder for a MIPS core with a valid/ready
// request/response handshake. Optional store trace under MIPS_DM_TRACE_EN.
module mips_dm_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
`ifdef MIPS_DM_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [31:0]       trace_pc,
  output logic [31:0]       trace_addr,
  output logic [31:0]       trace_data,
  output logic [15:0]       trace_cnt
`endif
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  dm_state_t         state;
  logic [IDX_W-1:0]  idx_p0;
  logic [MEM_AW-1:0] mem_idx_p0;
  logic              in_range_p0;
  logic [31:0]       rword_p0;
  logic              is_store_p0;
  logic              misalign_p0;
  logic [3:0]        be_p0;
  logic [31:0]       wlane_p0;
  logic [31:0]       ldata_p0;
  logic              err_p0;
  logic              accept_p0;
  logic              we_p0;

  // Stage p0: decode the presented request and read the addressed word.
  assign idx_p0      = req_addr[ADDR_W-1:2];
  assign in_range_p0 = idx_p0 < IDX_W'(DEPTH_WORDS);
  assign mem_idx_p0  = idx_p0[MEM_AW-1:0];
  assign rword_p0    = in_range_p0 ? mem[mem_idx_p0] : 32'h0;

  dm_lane_align u_align (
    .op       (req_op),
    .addr_lo  (req_addr[1:0]),
    .wdata    (req_wdata),
    .rword    (rword_p0),
    .is_store (is_store_p0),
    .misalign (misalign_p0),
    .be       (be_p0),
    .wlane    (wlane_p0),
    .ldata    (ldata_p0)
  );

  assign err_p0    = misalign_p0 || !in_range_p0;
  assign req_ready = (state == DM_IDLE) || resp_ready;
  assign accept_p0 = req_valid && req_ready;
  assign we_p0     = accept_p0 && is_store_p0 && !err_p0;

  // Memory array carries no reset; stores commit on the accepting edge so a
  // load accepted on the following edge sees the new data.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_p0 && be_p0[b]) mem[mem_idx_p0][8*b +: 8] <= wlane_p0[8*b +: 8];
    end
  end

`ifdef MIPS_DM_TRACE_EN
  logic [31:0] mask_p0;
  logic [31:0] merged_p0;

  assign mask_p0   = {{8{be_p0[3]}}, {8{be_p0[2]}}, {8{be_p0[1]}}, {8{be_p0[0]}}};
  assign merged_p0 = (rword_p0 & ~mask_p0) | (wlane_p0 & mask_p0);
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

  // Stage p1: registered response and control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= DM_IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
`ifdef MIPS_DM_TRACE_EN
      trace_valid <= 1'b0;
      trace_pc    <= 32'h0;
      trace_addr  <= 32'h0;
      trace_data  <= 32'h0;
      trace_cnt   <= 16'h0;
`endif
    end else begin
`ifdef MIPS_DM_TRACE_EN
      trace_valid <= 1'b0;
      if (we_p0) begin
        trace_valid <= 1'b1;
        trace_pc    <= req_pc;
        trace_addr  <= 32'({req_addr[ADDR_W-1:2], 2'b00});
        trace_data  <= merged_p0;
        trace_cnt   <= trace_cnt + 16'd1;
      end
`endif
      if (accept_p0) begin
        state      <= DM_RESP;
        resp_valid <= 1'b1;
        resp_err   <= err_p0;
        resp_rdata <= (err_p0 || is_store_p0) ? 32'h0 : ldata_p0;
      end else if (state == DM_RESP && resp_ready) begin
        state      <= DM_IDLE;
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_dm_responder.sv
// Randomized self-checking bench for mips_dm_responder against a byte-level
// memory model; adds trace checks when MIPS_DM_TRACE_EN is defined.
module tb_mips_dm_responder;

  localparam int OP_LW = 0, OP_LH = 1, OP_LHU = 2, OP_LB = 3;
  localparam int OP_LBU = 4, OP_SW = 5, OP_SH = 6, OP_SB = 7;
  localparam int DEPTH = 3072;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
`ifdef MIPS_DM_TRACE_EN
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [15:0] trace_cnt;
  int          pulses;
`endif

  mips_dm_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef MIPS_DM_TRACE_EN
    ,
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .trace_cnt   (trace_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  mb [int];
  int          pend_stall = 0;
  logic [31:0] last_rd    = 32'h0;
  int          exp_cnt    = 0;

`ifdef MIPS_DM_TRACE_EN
  always @(negedge clk) if (trace_valid === 1'b1) pulses++;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  function automatic logic [7:0] rd_byte(input int unsigned a);
    return mb.exists(int'(a)) ? mb[int'(a)] : 8'h00;
  endfunction

  // Reference model: byte-addressed little-endian memory.
  task automatic model_access(input int op, input int unsigned addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err,
                              output logic st, output logic [31:0] word);
    int size;
    logic [31:0] v;
    size = (op == OP_LW || op == OP_SW) ? 4 :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
    st  = (op >= OP_SW);
    err = ((addr % size) != 0) || ((addr / 4) >= DEPTH);
    if (!err && st)
      for (int i = 0; i < size; i++) mb[int'(addr) + i] = wd[8*i +: 8];
    v = 32'h0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = rd_byte(addr + i);
    if (op == OP_LH && v[15]) v[31:16] = 16'hFFFF;
    if (op == OP_LB && v[7])  v[31:8]  = 24'hFFFFFF;
    rd = (err || st) ? 32'h0 : v;
    for (int i = 0; i < 4; i++) word[8*i +: 8] = rd_byte((addr & ~32'h3) + i);
  endtask

  task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] pc, input int stall_after,
                       output logic [31:0] got_rd, output logic got_err);
    logic [31:0] erd, eword;
    logic        eerr, est;
    @(negedge clk);
    req_valid = 1'b1; req_op = op[2:0]; req_addr = addr; req_wdata = wd; req_pc = pc;
    resp_ready = 1'b0;
    #1;
    for (int k = 0; k < pend_stall; k++) begin
      chk("stall_resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("stall_resp_rdata", resp_rdata, last_rd);
      chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clk); #1;
    end
    resp_ready = 1'b1;
    #1;
    chk("req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_access(op, addr, wd, erd, eerr, est, eword);
    chk("resp_valid", {31'h0, resp_valid}, 32'h1);
    chk("resp_err", {31'h0, resp_err}, {31'h0, eerr});
    chk("resp_rdata", resp_rdata, erd);
`ifdef MIPS_DM_TRACE_EN
    if (est && !eerr) begin
      exp_cnt = (exp_cnt + 1) % 65536;
      chk("trace_valid", {31'h0, trace_valid}, 32'h1);
      chk("trace_cnt", {16'h0, trace_cnt}, exp_cnt);
      chk("trace_addr", trace_addr, addr & ~32'h3);
      chk("trace_data", trace_data, eword);
      chk("trace_pc", trace_pc, pc);
    end else begin
      chk("trace_quiet", {31'h0, trace_valid}, 32'h0);
    end
`endif
    got_rd = resp_rdata; got_err = resp_err;
    last_rd = erd;
    pend_stall = stall_after;
  endtask

  initial begin
    logic [31:0] rd, a, pc;
    logic        er;
    int          op, r;
    reset = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
    req_wdata = 32'h0; req_pc = 32'h0; resp_ready = 1'b0;
`ifdef MIPS_DM_TRACE_EN
    pulses = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    reset = 1'b1;

    pc = 32'h400000;
    for (int i = 0; i < 256; i += 4) begin
      issue(OP_SW, i, $urandom, pc, 0, rd, er); pc += 4;
    end
    for (int i = 32'h2FF0; i < 32'h3000; i += 4) begin
      issue(OP_SW, i, $urandom, pc, 0, rd, er); pc += 4;
    end

    issue(OP_SW, 32'h10, 32'h12345678, pc, 0, rd, er);
    issue(OP_LW, 32'h10, 32'h0, pc, 0, rd, er);
    chk("sw_lw_data", rd, 32'h12345678);
    chk("sw_lw_err", {31'h0, er}, 32'h0);
    issue(OP_SB, 32'h13, 32'h80, pc, 0, rd, er);
    issue(OP_LB, 32'h13, 32'h0, pc, 0, rd, er);
    chk("lb_sext", rd, 32'hFFFFFF80);
    issue(OP_LBU, 32'h13, 32'h0, pc, 0, rd, er);
    chk("lbu_zext", rd, 32'h00000080);
    issue(OP_LW, 32'h10, 32'h0, pc, 0, rd, er);
    chk("lw_after_sb", rd, 32'h80345678);
    issue(OP_LH, 32'h11, 32'h0, pc, 0, rd, er);
    chk("lh_mis_err", {31'h0, er}, 32'h1);
    chk("lh_mis_rdata", rd, 32'h0);
    issue(OP_SW, 32'h12, 32'hDEADBEEF, pc, 0, rd, er);
    chk("sw_mis_err", {31'h0, er}, 32'h1);
    issue(OP_LW, 32'h10, 32'h0, pc, 0, rd, er);
    chk("word_unchanged", rd, 32'h80345678);
    issue(OP_LW, 32'h3000, 32'h0, pc, 0, rd, er);
    chk("oor_err", {31'h0, er}, 32'h1);
    issue(OP_LW, 32'h2FFC, 32'h0, pc, 0, rd, er);
    chk("last_word_ok", {31'h0, er}, 32'h0);
    issue(OP_LW, 32'h10, 32'h0, pc, 3, rd, er);

    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 7);
      r  = $urandom_range(0, 9);
      if (r < 6)      a = $urandom_range(0, 255);
      else if (r < 8) a = 32'h2FF0 + $urandom_range(0, 15);
      else if (r < 9) a = 32'h3000 + $urandom_range(0, 255);
      else            a = $urandom | 32'h8000_0000;
      issue(op, a, $urandom, pc, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, rd, er);
      pc += 4;
    end

    // Reset while a response is held.
    issue(OP_LW, 32'h10, 32'h0, pc, 0, rd, er);
    @(negedge clk);
    resp_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rstresp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rstresp_rdata", resp_rdata, 32'h0);
    chk("rstresp_err", {31'h0, resp_err}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    pend_stall = 0;
    exp_cnt = 0;
`ifdef MIPS_DM_TRACE_EN
    pulses = 0;
`endif
    issue(OP_SW, 32'h20, 32'hCAFEF00D, 32'h3000, 0, rd, er);
    issue(OP_SW, 32'h24, 32'h0BADBEEF, 32'h3004, 0, rd, er);
    issue(OP_LW, 32'h20, 32'h0, pc, 0, rd, er);
    chk("post_rst_lw", rd, 32'hCAFEF00D);
    @(negedge clk);
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_resp_valid", {31'h0, resp_valid}, 32'h0);
`ifdef MIPS_DM_TRACE_EN
    chk("trace_pulses", pulses, 32'd2);
    chk("trace_cnt_final", {16'h0, trace_cnt}, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
